// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first,
// with the carry between digits kept in a register.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             accept;
  logic             last;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dsum;
  logic             c_msb;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == LAST);
  assign a_dig  = a_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign b_dig  = b_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dsum   = {1'b0, a_dig} + {1'b0, b_dig}
                + (DIGIT+1)'(carry_q);
  // Carry into the result MSB, recovered from the top digit's sum bit.
  assign c_msb  = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

  always_comb begin
    res_d = res_q;
    res_d[int'(cnt_q)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= cin ^ sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      res_q   <= res_d;
      carry_q <= dsum[DIGIT];
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        sum  <= res_d;
        cout <= dsum[DIGIT];
        ovf  <= c_msb ^ dsum[DIGIT];
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
